// File: rtl/sysbus_mem_responder_if.sv
// rtl/sysbus_mem_responder_if.sv - SysBus handshake and data signals between CPU side and memory responder
interface sysbus_mem_responder_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  ALE;
    logic                  nOE;
    logic                  nWE;
    logic [DATA_WIDTH-1:0] SysBusIn;
    logic [DATA_WIDTH-1:0] SysBusOut;
    logic                  SysBusOe;
    logic                  BusErr;

    modport master (
        output ALE, nOE, nWE, SysBusIn,
        input  SysBusOut, SysBusOe, BusErr
    );

    modport slave (
        input  ALE, nOE, nWE, SysBusIn,
        output SysBusOut, SysBusOe, BusErr
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - multiplexed SysBus memory responder with word RAM and backdoor load
module sysbus_mem_responder #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MEM_AW     = 10,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  Clock,
    input  logic                  nReset,
    sysbus_mem_responder_if.slave bus,
    input  logic                  LoadEn,
    input  logic [MEM_AW-1:0]     LoadAddr,
    input  logic [DATA_WIDTH-1:0] LoadData
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                state;
    logic [MEM_AW-1:0]     word_idx;
    logic                  hit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  drive_oe;
    logic                  bus_err;
    logic                  in_hit;
    logic                  bus_commit;

    logic [DATA_WIDTH-1:0] mem [0:(2**MEM_AW)-1];

    // Window decode of the address currently on the bus; only the word
    // index needs to be kept once the hit flag has been registered.
    assign in_hit = (bus.SysBusIn[DATA_WIDTH-1:MEM_AW] == BASE_ADDR[DATA_WIDTH-1:MEM_AW]);

    // The single write commit of an address phase happens on the edge that
    // first sees nWE low with nOE high; ALE always takes precedence.
    assign bus_commit = (state == ADDR) && !bus.ALE && bus.nOE && !bus.nWE && hit;

    assign bus.SysBusOut = rd_data;
    assign bus.SysBusOe  = drive_oe;
    assign bus.BusErr    = bus_err;

    // RAM write port: backdoor load first so a same-index bus commit overrides it.
    always_ff @(posedge Clock) begin
        if (LoadEn) begin
            mem[LoadAddr] <= LoadData;
        end
        if (bus_commit) begin
            mem[word_idx] <= bus.SysBusIn;
        end
    end

    // Bus cycle state machine with registered drive, read data and error pulse.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            word_idx <= '0;
            hit      <= 1'b0;
            rd_data  <= '0;
            drive_oe <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (bus.ALE) begin
                word_idx <= bus.SysBusIn[MEM_AW-1:0];
                hit      <= in_hit;
                drive_oe <= 1'b0;
                state    <= ADDR;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ADDR: begin
                        if (!bus.nOE && !bus.nWE) begin
                            bus_err <= 1'b1;
                            state   <= IDLE;
                        end else if (!bus.nOE) begin
                            if (hit) begin
                                rd_data  <= mem[word_idx];
                                drive_oe <= 1'b1;
                                state    <= READ;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (!bus.nWE) begin
                            state <= hit ? WRITE : IDLE;
                        end
                    end
                    READ: begin
                        if (!bus.nWE) begin
                            bus_err  <= 1'b1;
                            drive_oe <= 1'b0;
                            state    <= IDLE;
                        end else if (bus.nOE) begin
                            drive_oe <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    WRITE: begin
                        if (!bus.nOE) begin
                            bus_err <= 1'b1;
                            state   <= IDLE;
                        end else if (bus.nWE) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        drive_oe <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - self-checking bench for sysbus_mem_responder
module tb_sysbus_mem_responder;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          LoadEn = 1'b0;
    logic [AW-1:0] LoadAddr = '0;
    logic [DW-1:0] LoadData = '0;

    sysbus_mem_responder_if #(.DATA_WIDTH(DW)) sb ();

    sysbus_mem_responder #(
        .DATA_WIDTH(DW),
        .MEM_AW    (AW),
        .BASE_ADDR (16'h0000)
    ) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .bus     (sb),
        .LoadEn  (LoadEn),
        .LoadAddr(LoadAddr),
        .LoadData(LoadData)
    );

    always #5 Clock = ~Clock;

    // Reference memory: what every mapped word should hold right now.
    logic [DW-1:0] ref_mem [0:1023];
    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          setup;
        bit          exp_oe;
        logic [15:0] exp_d;
    } vec_t;
    vec_t tbl [10];

    function automatic bit in_window(input logic [15:0] a);
        return (a >> AW) == 16'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        sb.ALE = 1'b0;
        sb.nOE = 1'b1;
        sb.nWE = 1'b1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        LoadEn   = 1'b1;
        LoadAddr = a;
        LoadData = d;
        @(negedge Clock);
        LoadEn   = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic addr_phase(input logic [15:0] a, input int setup, input logic [15:0] sdata, input string tag);
        sb.ALE = 1'b1;
        sb.SysBusIn = a;
        sb.nOE = 1'b1;
        sb.nWE = 1'b1;
        @(negedge Clock);
        sb.ALE = 1'b0;
        sb.SysBusIn = sdata;
        for (int i = 0; i < setup; i++) begin
            @(negedge Clock);
            chk({tag, " setup oe"}, 32'(sb.SysBusOe), 32'd0);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input int setup, input int hold,
                           input bit exp_oe, input logic [15:0] exp_d, input string tag);
        addr_phase(a, setup, 16'($urandom), tag);
        sb.nOE = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            @(negedge Clock);
            chk({tag, " rd oe"}, 32'(sb.SysBusOe), 32'(exp_oe));
            if (exp_oe) chk({tag, " rd data"}, 32'(sb.SysBusOut), 32'(exp_d));
            chk({tag, " rd err"}, 32'(sb.BusErr), 32'd0);
        end
        sb.nOE = 1'b1;
        @(negedge Clock);
        chk({tag, " rd release oe"}, 32'(sb.SysBusOe), 32'd0);
    endtask

    task automatic do_write(input logic [15:0] a, input int setup, input int hold,
                            input logic [15:0] d, input string tag);
        addr_phase(a, setup, d, tag);
        sb.nWE = 1'b0;
        sb.SysBusIn = d;
        for (int i = 0; i <= hold; i++) begin
            @(negedge Clock);
            chk({tag, " wr oe"}, 32'(sb.SysBusOe), 32'd0);
            chk({tag, " wr err"}, 32'(sb.BusErr), 32'd0);
            sb.SysBusIn = 16'hFFFF;
        end
        sb.nWE = 1'b1;
        @(negedge Clock);
        if (in_window(a)) ref_mem[a[AW-1:0]] = d;
    endtask

    initial begin
        logic [15:0] a, d, old;
        bus_idle();
        sb.SysBusIn = '0;

        // Reset state
        #1;
        chk("reset oe",  32'(sb.SysBusOe),  32'd0);
        chk("reset out", 32'(sb.SysBusOut), 32'd0);
        chk("reset err", 32'(sb.BusErr),    32'd0);
        @(negedge Clock);
        nReset = 1'b1;

        // Preload every word so all later reads have known contents
        for (int i = 0; i < 1024; i++) load(AW'(i), 16'(i * 40503) ^ 16'h5A5A);
        load(10'h005, 16'hBEEF);
        load(10'h000, 16'hA5A5);
        load(10'h3FF, 16'h7E57);
        load(10'h006, 16'h6666);

        tbl[0] = '{1'b0, 16'h0005, 16'h0000, 0, 1'b1, 16'hBEEF};
        tbl[1] = '{1'b1, 16'h0010, 16'h1234, 1, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 16'h0010, 16'h0000, 2, 1'b1, 16'h1234};
        tbl[3] = '{1'b0, 16'h0400, 16'h0000, 0, 1'b0, 16'h0000};
        tbl[4] = '{1'b1, 16'h0400, 16'hDEAD, 0, 1'b0, 16'h0000};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1, 1'b1, 16'hA5A5};
        tbl[6] = '{1'b0, 16'h03FF, 16'h0000, 0, 1'b1, 16'h7E57};
        tbl[7] = '{1'b0, 16'hFC05, 16'h0000, 0, 1'b0, 16'h0000};
        tbl[8] = '{1'b1, 16'h03FF, 16'h0F0F, 0, 1'b0, 16'h0000};
        tbl[9] = '{1'b0, 16'h03FF, 16'h0000, 0, 1'b1, 16'h0F0F};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].setup, 1, tbl[i].data, $sformatf("tbl%0d", i));
            else           do_read(tbl[i].addr, tbl[i].setup, 1, tbl[i].exp_oe, tbl[i].exp_d, $sformatf("tbl%0d", i));
        end

        // Randomized transactions against the reference memory
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                do_write(a, $urandom_range(0, 2), $urandom_range(0, 2), d, $sformatf("rnd%0d", i));
            end else begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), in_window(a),
                        ref_mem[a[AW-1:0]], $sformatf("rnd%0d", i));
            end
        end

        // Both strobes low after ALE: one-cycle error, nothing written
        old = ref_mem[10'h020];
        addr_phase(16'h0020, 0, 16'h0000, "viol");
        sb.nOE = 1'b0;
        sb.nWE = 1'b0;
        sb.SysBusIn = 16'hFFFF;
        @(negedge Clock);
        chk("viol err", 32'(sb.BusErr), 32'd1);
        chk("viol oe",  32'(sb.SysBusOe), 32'd0);
        bus_idle();
        @(negedge Clock);
        chk("viol err clear", 32'(sb.BusErr), 32'd0);
        do_read(16'h0020, 0, 0, 1'b1, old, "viol after");

        // Strobes without ALE are ignored
        sb.nOE = 1'b0;
        repeat (3) @(negedge Clock);
        chk("idle oe",  32'(sb.SysBusOe), 32'd0);
        chk("idle err", 32'(sb.BusErr),   32'd0);
        bus_idle();
        @(negedge Clock);

        // ALE during a read aborts it, then the new address is served
        addr_phase(16'h0005, 0, 16'h0000, "abort");
        sb.nOE = 1'b0;
        @(negedge Clock);
        chk("abort pre oe", 32'(sb.SysBusOe), 32'd1);
        sb.ALE = 1'b1;
        sb.SysBusIn = 16'h0006;
        @(negedge Clock);
        chk("abort oe", 32'(sb.SysBusOe), 32'd0);
        sb.ALE = 1'b0;
        @(negedge Clock);
        chk("abort new oe",   32'(sb.SysBusOe),  32'd1);
        chk("abort new data", 32'(sb.SysBusOut), 32'h6666);
        bus_idle();
        @(negedge Clock);

        // nWE during a read is a violation
        addr_phase(16'h0005, 0, 16'h0000, "rdwe");
        sb.nOE = 1'b0;
        @(negedge Clock);
        sb.nWE = 1'b0;
        @(negedge Clock);
        chk("rdwe err", 32'(sb.BusErr),   32'd1);
        chk("rdwe oe",  32'(sb.SysBusOe), 32'd0);
        bus_idle();
        @(negedge Clock);

        // nOE during a write is a violation but the committed data stands
        addr_phase(16'h0040, 0, 16'h0000, "wroe");
        sb.nWE = 1'b0;
        sb.SysBusIn = 16'h4321;
        @(negedge Clock);
        sb.nOE = 1'b0;
        @(negedge Clock);
        chk("wroe err", 32'(sb.BusErr),   32'd1);
        chk("wroe oe",  32'(sb.SysBusOe), 32'd0);
        bus_idle();
        @(negedge Clock);
        do_read(16'h0040, 0, 0, 1'b1, 16'h4321, "wroe after");

        // Bus commit and backdoor load on the same edge and index: bus wins
        addr_phase(16'h0030, 0, 16'hC0DE, "coll");
        sb.nWE = 1'b0;
        LoadEn = 1'b1;
        LoadAddr = 10'h030;
        LoadData = 16'h1111;
        @(negedge Clock);
        LoadEn = 1'b0;
        bus_idle();
        @(negedge Clock);
        do_read(16'h0030, 0, 0, 1'b1, 16'hC0DE, "coll after");

        // Read sampled on the same edge as a load to that index sees the old word
        old = ref_mem[10'h031];
        addr_phase(16'h0031, 0, 16'h0000, "rbw");
        sb.nOE = 1'b0;
        LoadEn = 1'b1;
        LoadAddr = 10'h031;
        LoadData = 16'h2222;
        @(negedge Clock);
        LoadEn = 1'b0;
        chk("rbw old data", 32'(sb.SysBusOut), 32'(old));
        bus_idle();
        @(negedge Clock);
        do_read(16'h0031, 0, 0, 1'b1, 16'h2222, "rbw new");

        // Asynchronous reset in the middle of a read
        addr_phase(16'h0005, 0, 16'h0000, "rst");
        sb.nOE = 1'b0;
        @(negedge Clock);
        chk("rst pre oe", 32'(sb.SysBusOe), 32'd1);
        #2 nReset = 1'b0;
        #1;
        chk("rst oe",  32'(sb.SysBusOe),  32'd0);
        chk("rst out", 32'(sb.SysBusOut), 32'd0);
        bus_idle();
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        do_read(16'h0005, 0, 0, 1'b1, 16'hBEEF, "rst after");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
